i2c_mem_ctrl_multi: RTL and testbench

Parametrised memory-access controller for the I2C subordinate. It sits between the I2C bit/byte engine and a single-port synchronous RAM. It decodes the register-address phase (1–N address bytes), performs auto-incrementing burst writes and reads, and decides the subordinate ACK/NACK for each data byte. It adds configurable depth, multi-byte addressing, wrap/saturate policy and out-of-range handling.

---
 rtl/i2c_mem_ctrl_multi_if.sv | 40 ++++
 rtl/i2c_mem_ctrl_multi.sv | 197 +++++++++++++++++++
 tb/tb_i2c_mem_ctrl_multi.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_mem_ctrl_multi_if.sv
// Engine-side and RAM-side signal bundle for the I2C subordinate memory controller.
// The slave modport is the controller; the master modport is the engine/RAM side.
interface i2c_mem_ctrl_multi_if #(
    parameter int unsigned MEM_AW = 8
) ();
    logic              start_det;
    logic              stop_det;
    logic              dev_match;
    logic              dev_rw;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_ack;
    logic              tx_req;
    logic              tx_valid;
    logic [7:0]        tx_byte;
    logic              tx_ack;
    logic              tx_nack;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic [MEM_AW:0]   ptr;
    logic              busy;
    logic              ovf;

    modport slave (
        input  start_det, stop_det, dev_match, dev_rw, rx_valid, rx_byte,
        input  tx_req, tx_ack, tx_nack, mem_rdata,
        output rx_ack, tx_valid, tx_byte, mem_addr, mem_wdata, mem_we, mem_re,
        output ptr, busy, ovf
    );

    modport master (
        output start_det, stop_det, dev_match, dev_rw, rx_valid, rx_byte,
        output tx_req, tx_ack, tx_nack, mem_rdata,
        input  rx_ack, tx_valid, tx_byte, mem_addr, mem_wdata, mem_we, mem_re,
        input  ptr, busy, ovf
    );
endinterface

// File: rtl/i2c_mem_ctrl_multi.sv
// Memory-access controller for an I2C subordinate: decodes a multi-byte register address,
// then runs auto-incrementing burst writes/reads against a single-port synchronous RAM.
module i2c_mem_ctrl_multi #(
    parameter int unsigned ADDR_BYTES = 1,
    parameter int unsigned MEM_AW     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter bit          WRAP       = 1'b1,
    parameter logic [7:0]  OOR_DATA   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_mem_ctrl_multi_if.slave   bus
);
    localparam int unsigned PW = MEM_AW + 1;
    localparam int unsigned SW = 8 * ADDR_BYTES;
    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [PW-1:0] LAST_P    = PW'(DEPTH - 1);
    localparam logic [2:0]    LAST_BYTE = 3'(ADDR_BYTES - 1);

    typedef enum logic [6:0] {
        StIdle   = 7'b0000001,
        StAddr   = 7'b0000010,
        StWrData = 7'b0000100,
        StRdWait = 7'b0001000,
        StFetch  = 7'b0010000,
        StLoad   = 7'b0100000,
        StRdSent = 7'b1000000
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [SW-1:0]     sr_q, sr_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        tx_byte_q, tx_byte_d;

    logic              in_range;
    logic [7:0]        load_byte;
    logic [SW-1:0]     sr_next;
    logic [PW-1:0]     ptr_load;
    logic [PW-1:0]     ptr_inc;
    logic              inc_ovf;

    assign in_range  = (ptr_q < DEPTH_P);
    assign load_byte = in_range ? bus.mem_rdata : OOR_DATA;
    assign sr_next   = SW'({sr_q, bus.rx_byte});
    // Only the low MEM_AW bits of the big-endian address select a location.
    assign ptr_load  = PW'(MEM_AW'({{MEM_AW{1'b0}}, sr_next}));

    always_comb begin
        ptr_inc = ptr_q;
        inc_ovf = 1'b0;
        if (ptr_q == LAST_P) begin
            if (WRAP) begin
                ptr_inc = '0;
            end else begin
                ptr_inc = DEPTH_P;
                inc_ovf = 1'b1;
            end
        end else if (in_range) begin
            ptr_inc = ptr_q + PW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_byte_d   = tx_byte_q;

        if (bus.stop_det || bus.start_det) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.dev_match) begin
                        ovf_d = 1'b0;
                        if (bus.dev_rw) begin
                            state_d = StRdWait;
                        end else begin
                            state_d = StAddr;
                            cnt_d   = '0;
                            sr_d    = '0;
                        end
                    end
                end
                StAddr: begin
                    if (bus.rx_valid) begin
                        sr_d  = sr_next;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == LAST_BYTE) begin
                            ptr_d   = ptr_load;
                            state_d = StWrData;
                        end
                    end
                end
                StWrData: begin
                    if (bus.rx_valid) begin
                        if (in_range) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = ptr_q[MEM_AW-1:0];
                            mem_wdata_d = bus.rx_byte;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                StRdWait: begin
                    if (bus.tx_req) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = ptr_q[MEM_AW-1:0];
                        state_d    = StFetch;
                    end
                end
                StFetch: begin
                    state_d = StLoad;
                end
                StLoad: begin
                    state_d = StRdSent;
                end
                StRdSent: begin
                    if (bus.tx_ack || bus.tx_nack) begin
                        ptr_d   = ptr_inc;
                        ovf_d   = ovf_q | inc_ovf;
                        state_d = bus.tx_ack ? StRdWait : StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // The byte on the bus during LOAD is latched even if the transfer is cut short.
        if (state_q == StLoad) begin
            tx_byte_d = load_byte;
            if (!in_range) begin
                ovf_d = 1'b1;
            end
        end

        // A write issued last cycle advances the pointer while mem_we is on the bus.
        if (mem_we_q) begin
            ptr_d = ptr_inc;
            if (inc_ovf) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            sr_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    assign bus.rx_ack    = (state_q == StAddr) || ((state_q == StWrData) && in_range);
    assign bus.tx_valid  = (state_q == StLoad);
    assign bus.tx_byte   = (state_q == StLoad) ? load_byte : tx_byte_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.ptr       = ptr_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_i2c_mem_ctrl_multi.sv
// Scoreboard bench: two controllers (wrap and saturate, DEPTH=200, 2 address bytes) see
// identical engine stimulus; expected RAM writes and transmitted bytes are queued per DUT.
module tb_i2c_mem_ctrl_multi;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 200;

    logic clk = 1'b0;
    logic rst;
    logic ram_init;
    logic start_det, stop_det, dev_match, dev_rw, rx_valid, tx_req, tx_ack, tx_nack;
    logic [7:0] rx_byte;

    always #5 clk = ~clk;

    i2c_mem_ctrl_multi_if #(.MEM_AW(AW)) if_w ();
    i2c_mem_ctrl_multi_if #(.MEM_AW(AW)) if_s ();

    assign if_w.start_det = start_det;
    assign if_w.stop_det  = stop_det;
    assign if_w.dev_match = dev_match;
    assign if_w.dev_rw    = dev_rw;
    assign if_w.rx_valid  = rx_valid;
    assign if_w.rx_byte   = rx_byte;
    assign if_w.tx_req    = tx_req;
    assign if_w.tx_ack    = tx_ack;
    assign if_w.tx_nack   = tx_nack;
    assign if_s.start_det = start_det;
    assign if_s.stop_det  = stop_det;
    assign if_s.dev_match = dev_match;
    assign if_s.dev_rw    = dev_rw;
    assign if_s.rx_valid  = rx_valid;
    assign if_s.rx_byte   = rx_byte;
    assign if_s.tx_req    = tx_req;
    assign if_s.tx_ack    = tx_ack;
    assign if_s.tx_nack   = tx_nack;

    i2c_mem_ctrl_multi #(
        .ADDR_BYTES(2), .MEM_AW(AW), .DEPTH(DEPTH), .WRAP(1'b1), .OOR_DATA(8'hFF)
    ) u_wrap (
        .clk(clk), .rst(rst), .bus(if_w.slave)
    );

    i2c_mem_ctrl_multi #(
        .ADDR_BYTES(2), .MEM_AW(AW), .DEPTH(DEPTH), .WRAP(1'b0), .OOR_DATA(8'hFF)
    ) u_sat (
        .clk(clk), .rst(rst), .bus(if_s.slave)
    );

    // Synchronous RAM models, preloaded with addr ^ 0x3C.
    logic [7:0] ram_w [256];
    logic [7:0] ram_s [256];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) begin
                ram_w[i] <= 8'(i) ^ 8'h3C;
                ram_s[i] <= 8'(i) ^ 8'h3C;
            end
        end else begin
            if (if_w.mem_we) ram_w[if_w.mem_addr] <= if_w.mem_wdata;
            if (if_w.mem_re) if_w.mem_rdata <= ram_w[if_w.mem_addr];
            if (if_s.mem_we) ram_s[if_s.mem_addr] <= if_s.mem_wdata;
            if (if_s.mem_re) if_s.mem_rdata <= ram_s[if_s.mem_addr];
        end
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq_w[$];
    wr_t        wq_s[$];
    logic [7:0] tq_w[$];
    logic [7:0] tq_s[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] t;
        if (if_w.mem_we === 1'b1) begin
            if (wq_w.size() == 0) check("w_unexpected_we", 1, 0);
            else begin
                e = wq_w.pop_front();
                check("w_write", {if_w.mem_addr, if_w.mem_wdata}, e);
            end
        end
        if (if_s.mem_we === 1'b1) begin
            if (wq_s.size() == 0) check("s_unexpected_we", 1, 0);
            else begin
                e = wq_s.pop_front();
                check("s_write", {if_s.mem_addr, if_s.mem_wdata}, e);
            end
        end
        if (if_w.tx_valid === 1'b1) begin
            if (tq_w.size() == 0) check("w_unexpected_tx", 1, 0);
            else begin
                t = tq_w.pop_front();
                check("w_tx_byte", if_w.tx_byte, t);
            end
        end
        if (if_s.tx_valid === 1'b1) begin
            if (tq_s.size() == 0) check("s_unexpected_tx", 1, 0);
            else begin
                t = tq_s.pop_front();
                check("s_tx_byte", if_s.tx_byte, t);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_det = 1'b1; tick(); start_det = 1'b0; tick();
    endtask

    task automatic pulse_stop();
        stop_det = 1'b1; tick(); stop_det = 1'b0; tick();
    endtask

    task automatic match(input logic rw);
        dev_rw = rw; dev_match = 1'b1; tick(); dev_match = 1'b0; tick();
    endtask

    task automatic rx(input logic [7:0] b, input logic ack_w, input logic ack_s);
        rx_byte  = b;
        rx_valid = 1'b1;
        check("w_rx_ack", if_w.rx_ack, ack_w);
        check("s_rx_ack", if_s.rx_ack, ack_s);
        tick();
        rx_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic set_addr(input logic [15:0] a);
        match(1'b0);
        rx(a[15:8], 1'b1, 1'b1);
        rx(a[7:0], 1'b1, 1'b1);
    endtask

    task automatic rd(input logic [7:0] exp_w, input logic [7:0] exp_s,
                      input logic [7:0] addr_w, input logic [7:0] addr_s, input logic last);
        tq_w.push_back(exp_w);
        tq_s.push_back(exp_s);
        tx_req = 1'b1; tick(); tx_req = 1'b0;
        check("w_mem_re", if_w.mem_re, 1);
        check("s_mem_re", if_s.mem_re, 1);
        check("w_re_addr", if_w.mem_addr, addr_w);
        check("s_re_addr", if_s.mem_addr, addr_s);
        check("w_tx_valid_early", if_w.tx_valid, 0);
        tick();
        check("w_tx_valid", if_w.tx_valid, 1);
        check("s_tx_valid", if_s.tx_valid, 1);
        tick();
        if (last) tx_nack = 1'b1;
        else tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0; tx_nack = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag_w, input string tag_s);
        check(tag_w, {if_w.ptr, if_w.busy, if_w.ovf, if_w.tx_valid, if_w.mem_we, if_w.mem_re,
                      if_w.tx_byte, if_w.mem_addr, if_w.mem_wdata, if_w.rx_ack}, 0);
        check(tag_s, {if_s.ptr, if_s.busy, if_s.ovf, if_s.tx_valid, if_s.mem_we, if_s.mem_re,
                      if_s.tx_byte, if_s.mem_addr, if_s.mem_wdata, if_s.rx_ack}, 0);
    endtask

    initial begin
        rst = 1'b1; ram_init = 1'b1;
        {start_det, stop_det, dev_match, dev_rw, rx_valid, tx_req, tx_ack, tx_nack} = '0;
        rx_byte = '0;
        repeat (3) @(posedge clk);
        #1 ram_init = 1'b0;
        chk_all_zero("w_reset_outputs", "s_reset_outputs");
        rst = 1'b0;
        tick();

        // Burst write of two bytes at 0x0010.
        set_addr(16'h0010);
        wq_w.push_back('{8'h10, 8'hA5}); wq_s.push_back('{8'h10, 8'hA5});
        rx(8'hA5, 1'b1, 1'b1);
        wq_w.push_back('{8'h11, 8'h5A}); wq_s.push_back('{8'h11, 8'h5A});
        rx(8'h5A, 1'b1, 1'b1);
        check("w_ptr_after_burst", if_w.ptr, 9'h012);
        check("s_ptr_after_burst", if_s.ptr, 9'h012);
        check("w_busy_in_write", if_w.busy, 1);
        pulse_stop();
        check("w_busy_after_stop", if_w.busy, 0);

        // Random read of the same two bytes.
        pulse_start();
        set_addr(16'h0010);
        pulse_start();
        match(1'b1);
        check("w_busy_rd", if_w.busy, 1);
        rd(8'hA5, 8'hA5, 8'h10, 8'h10, 1'b0);
        rd(8'h5A, 8'h5A, 8'h11, 8'h11, 1'b1);
        check("w_busy_after_nack", if_w.busy, 0);
        check("s_busy_after_nack", if_s.busy, 0);
        check("w_ptr_after_read", if_w.ptr, 9'h012);
        check("s_ptr_after_read", if_s.ptr, 9'h012);

        // Boundary: burst of two from DEPTH-1.
        pulse_start();
        set_addr(16'h00C7);
        wq_w.push_back('{8'hC7, 8'h11}); wq_s.push_back('{8'hC7, 8'h11});
        rx(8'h11, 1'b1, 1'b1);
        check("w_ovf_after_last", if_w.ovf, 0);
        check("s_ovf_after_last", if_s.ovf, 1);
        wq_w.push_back('{8'h00, 8'h22});
        rx(8'h22, 1'b1, 1'b0);
        check("w_ptr_wrapped", if_w.ptr, 9'd1);
        check("s_ptr_saturated", if_s.ptr, 9'd200);
        check("w_ovf_wrap", if_w.ovf, 0);
        check("s_ovf_sat", if_s.ovf, 1);
        pulse_start();
        match(1'b1);
        check("s_ovf_cleared", if_s.ovf, 0);
        rd(8'h01 ^ 8'h3C, 8'hFF, 8'h01, 8'hC8, 1'b1);
        check("s_ovf_oor_read", if_s.ovf, 1);
        check("w_ovf_read", if_w.ovf, 0);
        check("w_ptr_after_rd", if_w.ptr, 9'd2);
        check("s_ptr_stays", if_s.ptr, 9'd200);

        // STOP after the first of two address bytes.
        pulse_start();
        match(1'b0);
        rx(8'h00, 1'b1, 1'b1);
        pulse_stop();
        check("w_ptr_kept", if_w.ptr, 9'd2);
        check("s_ptr_kept", if_s.ptr, 9'd200);
        check("w_busy_stop_addr", if_w.busy, 0);
        check("w_rx_ack_idle", if_w.rx_ack, 0);

        // Reset lands the cycle after rx_valid in WR_DATA.
        pulse_start();
        set_addr(16'h0040);
        rx_byte = 8'h77; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("w_mid_reset_outputs", "s_mid_reset_outputs");
        tick(); tick();
        rst = 1'b0;
        tick();
        check("w_no_partial_write", ram_w[8'h40], 8'h40 ^ 8'h3C);
        check("s_no_partial_write", ram_s[8'h40], 8'h40 ^ 8'h3C);
        check("w_busy_post_reset", if_w.busy, 0);

        repeat (4) tick();
        check("w_writes_outstanding", wq_w.size(), 0);
        check("s_writes_outstanding", wq_s.size(), 0);
        check("w_tx_outstanding", tq_w.size(), 0);
        check("s_tx_outstanding", tq_s.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end
endmodule
